program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of program-memory words.
REQ-002 SHALL have parameter ADDR_W, default 5, program-memory address width; DEPTH <= 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  request new load; sampled in IDLE only.
REQ-006 SHALL have port InValid  input  1  InData holds a valid byte.
REQ-007 SHALL have port InData  input  8  byte stream from host.
REQ-008 SHALL have port InReady  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port PM_WE  output  1  program-memory write strobe.
REQ-010 SHALL have port PM_Addr  output  ADDR_W  program-memory write address.
REQ-011 SHALL have port PM_Data  output  13  instruction word to write.
REQ-012 SHALL have port CpuHold  output  1  holds processor in reset; processor reset = external reset OR CpuHold.
REQ-013 SHALL have ports Busy, Done, Error  output  1 each  load in progress / one-cycle completion pulse / sticky failure flag.

Function
REQ-014 Byte is accepted on a rising edge where InValid && InReady; no other edge consumes a byte.
REQ-015 FSM states: IDLE, COUNT, HI, LO, WRITE, CHECK, FINISH.
REQ-016 IDLE: InReady=0; Start=1 -> COUNT, Error cleared, CpuHold set, Busy set, word counter and address cleared.
REQ-017 COUNT: InReady=1; accepted byte N latched; N in 1..DEPTH -> HI; N=0 or N>DEPTH -> IDLE with Error=1, CpuHold stays 1.
REQ-018 HI: InReady=1; accepted byte bits [4:0] latched as instruction bits [12:8]; bits [7:5] ignored -> LO.
REQ-019 LO: InReady=1; accepted byte latched as bits [7:0] -> WRITE.
REQ-020 WRITE: InReady=0; PM_WE=1 for exactly this cycle with PM_Addr = current address, PM_Data = assembled word; address and word count increment at end of cycle.
REQ-021 After WRITE: words written < N -> HI; = N -> CHECK (checksum enabled) or FINISH (disabled).
REQ-022 FINISH: Done=1 for one cycle, CpuHold cleared, Busy cleared -> IDLE.
REQ-023 Write latency: PM_WE asserts on the cycle after the LO byte is accepted.
REQ-024 Address never wraps; maximum written address is DEPTH-1; words beyond N never written.
REQ-025 Start asserted outside IDLE SHALL be ignored; InValid in IDLE/WRITE SHALL be ignored (byte held by host).
REQ-026 PM_WE=0 in every state except WRITE; PM_Addr/PM_Data hold last value otherwise.
REQ-027 Busy=1 in all states except IDLE; Error remains 1 until next accepted Start or Reset.

Reset
REQ-028 Reset=1 SHALL immediately force IDLE, InReady=0, PM_WE=0, PM_Addr=0, PM_Data=0, CpuHold=0, Busy=0, Done=0, Error=0, counters 0.
REQ-029 Reset mid-load SHALL abort without further writes; partially written memory contents are not restored.

Configuration
REQ-030 Macro LOADER_CHECKSUM_EN defined: running sum mod 256 of all accepted bytes (count, HI, LO) kept; CHECK state InReady=1, accepted byte compared to sum; match -> FINISH; mismatch -> IDLE with Error=1, CpuHold=1, no Done.
REQ-031 Macro undefined: no CHECK state, no sum register; last WRITE goes directly to FINISH.

Verification
REQ-032 Start, bytes 01,1F,AB (+checksum CB if enabled) -> one PM_WE at addr 0, PM_Data=0x1FAB, Done pulse, CpuHold 1->0.
REQ-033 Start, N=32 with 64 bytes, InValid toggling randomly -> 32 writes addresses 0..31 in order, none to 32, Done once.
REQ-034 Start, count byte 00 then 21 (separate runs) -> no PM_WE, Error=1, CpuHold=1, back to IDLE; next Start clears Error.
REQ-035 LOADER_CHECKSUM_EN: bytes 01,00,05, checksum 07 -> Error=1, no Done; checksum 06 -> Done.
REQ-036 Reset asserted after HI byte of word 3 -> all outputs at reset values same cycle, no write to addr 3; new load succeeds.
REQ-037 Start pulsed during HI state -> ignored, load completes unaffected.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: streams a length-prefixed byte image into program memory while holding the CPU in reset.
// Optional trailing mod-256 checksum verification is enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic              InValid,
   input  logic [7:0]        InData,
   output logic              InReady,
   output logic              PM_WE,
   output logic [ADDR_W-1:0] PM_Addr,
   output logic [12:0]       PM_Data,
   output logic              CpuHold,
   output logic              Busy,
   output logic              Done,
   output logic              Error
);

   // Count byte is 8 bits wide, so a 9-bit depth constant is enough for the range check.
   localparam logic [8:0]        LP_DEPTH    = 9'(DEPTH);
   localparam logic [ADDR_W-1:0] LP_ADDR_ONE = ADDR_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COUNT,
      S_HI,
      S_LO,
      S_WRITE,
`ifdef LOADER_CHECKSUM_EN
      S_CHECK,
`endif
      S_FINISH
   } state_t;

   state_t            r_state;
   logic              r_in_ready;
   logic              r_pm_we;
   logic [ADDR_W-1:0] r_pm_addr;
   logic [12:0]       r_pm_data;
   logic              r_cpu_hold;
   logic              r_busy;
   logic              r_done;
   logic              r_error;
   logic [7:0]        r_count;
   logic [7:0]        r_words;
   logic [ADDR_W-1:0] r_addr;
   logic [4:0]        r_hi;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        r_sum;
   logic [7:0]        w_sum_next;
`endif

   logic              w_accept;
   logic              w_count_bad;
   logic [7:0]        w_words_next;
   logic              w_last_word;

   assign w_accept     = InValid & r_in_ready;
   assign w_count_bad  = (InData == 8'd0) || ({1'b0, InData} > LP_DEPTH);
   assign w_words_next = r_words + 8'd1;
   assign w_last_word  = (w_words_next == r_count);
`ifdef LOADER_CHECKSUM_EN
   assign w_sum_next   = r_sum + InData;
`endif

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_state    <= S_IDLE;
         r_in_ready <= 1'b0;
         r_pm_we    <= 1'b0;
         r_pm_addr  <= '0;
         r_pm_data  <= '0;
         r_cpu_hold <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_count    <= '0;
         r_words    <= '0;
         r_addr     <= '0;
         r_hi       <= '0;
`ifdef LOADER_CHECKSUM_EN
         r_sum      <= '0;
`endif
      end else begin
         r_pm_we <= 1'b0;
         r_done  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         // Every accepted byte (count, HI, LO and the checksum itself) feeds the sum;
         // the checksum byte is compared against the value before its own addition.
         if (w_accept) begin
            r_sum <= w_sum_next;
         end
`endif
         case (r_state)
            S_IDLE: begin
               r_in_ready <= 1'b0;
               if (Start) begin
                  r_state    <= S_COUNT;
                  r_in_ready <= 1'b1;
                  r_error    <= 1'b0;
                  r_cpu_hold <= 1'b1;
                  r_busy     <= 1'b1;
                  r_count    <= '0;
                  r_words    <= '0;
                  r_addr     <= '0;
`ifdef LOADER_CHECKSUM_EN
                  r_sum      <= '0;
`endif
               end
            end
            S_COUNT: begin
               if (w_accept) begin
                  r_count <= InData;
                  if (w_count_bad) begin
                     // CpuHold stays asserted so a failed load never releases the CPU.
                     r_state    <= S_IDLE;
                     r_in_ready <= 1'b0;
                     r_busy     <= 1'b0;
                     r_error    <= 1'b1;
                  end else begin
                     r_state <= S_HI;
                  end
               end
            end
            S_HI: begin
               if (w_accept) begin
                  r_hi    <= InData[4:0];
                  r_state <= S_LO;
               end
            end
            S_LO: begin
               if (w_accept) begin
                  r_state    <= S_WRITE;
                  r_in_ready <= 1'b0;
                  r_pm_we    <= 1'b1;
                  r_pm_addr  <= r_addr;
                  r_pm_data  <= {r_hi, InData};
               end
            end
            S_WRITE: begin
               r_words <= w_words_next;
               if (!w_last_word) begin
                  // Address only advances when another word follows, so it never passes DEPTH-1.
                  r_addr     <= r_addr + LP_ADDR_ONE;
                  r_state    <= S_HI;
                  r_in_ready <= 1'b1;
               end else begin
`ifdef LOADER_CHECKSUM_EN
                  r_state    <= S_CHECK;
                  r_in_ready <= 1'b1;
`else
                  r_state    <= S_FINISH;
                  r_done     <= 1'b1;
`endif
               end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
               if (w_accept) begin
                  r_in_ready <= 1'b0;
                  if (InData == r_sum) begin
                     r_state <= S_FINISH;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                     r_error <= 1'b1;
                  end
               end
            end
`endif
            S_FINISH: begin
               r_state    <= S_IDLE;
               r_in_ready <= 1'b0;
               r_cpu_hold <= 1'b0;
               r_busy     <= 1'b0;
            end
            default: begin
               r_state    <= S_IDLE;
               r_in_ready <= 1'b0;
            end
         endcase
      end
   end

   assign InReady = r_in_ready;
   assign PM_WE   = r_pm_we;
   assign PM_Addr = r_pm_addr;
   assign PM_Data = r_pm_data;
   assign CpuHold = r_cpu_hold;
   assign Busy    = r_busy;
   assign Done    = r_done;
   assign Error   = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader: a cycle-accurate vector table plus hand-written load sequences.
// Define LOADER_CHECKSUM_EN for both this file and the RTL to exercise the checksum variant.
`define CHK(NAME, ACT, EXP) begin checks++; if ((ACT) !== (EXP)) begin errors++; $display("FAIL %s: got %0h expected %0h", NAME, ACT, EXP); end end

module tb_program_loader;
   localparam int DEPTH  = 32;
   localparam int ADDR_W = 5;

   logic              clk;
   logic              Reset;
   logic              Start;
   logic              InValid;
   logic [7:0]        InData;
   logic              InReady;
   logic              PM_WE;
   logic [ADDR_W-1:0] PM_Addr;
   logic [12:0]       PM_Data;
   logic              CpuHold;
   logic              Busy;
   logic              Done;
   logic              Error;

   program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .Reset(Reset), .Start(Start), .InValid(InValid), .InData(InData),
      .InReady(InReady), .PM_WE(PM_WE), .PM_Addr(PM_Addr), .PM_Data(PM_Data),
      .CpuHold(CpuHold), .Busy(Busy), .Done(Done), .Error(Error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit rnd_valid = 1'b0;

   // Write / done monitor: one line per memory write transaction.
   logic [ADDR_W-1:0] wr_addr_q[$];
   logic [12:0]       wr_data_q[$];
   int                done_cnt = 0;

   always @(negedge clk) begin
      if (PM_WE) begin
         wr_addr_q.push_back(PM_Addr);
         wr_data_q.push_back(PM_Data);
         $display("write addr=%0d data=%04h", PM_Addr, PM_Data);
      end
      if (Done) begin
         done_cnt++;
         $display("done pulse at %0t", $time);
      end
   end

   typedef struct packed {
      logic        start;
      logic        valid;
      logic [7:0]  data;
      logic        rdy;
      logic        we;
      logic [4:0]  addr;
      logic [12:0] pdata;
      logic        hold;
      logic        busy;
      logic        done;
      logic        err;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic st, input logic v, input logic [7:0] d,
                          input logic rdy, input logic we, input logic [4:0] a, input logic [12:0] pd,
                          input logic hold, input logic busy, input logic done, input logic err);
      vec_t t;
      t = '{st, v, d, rdy, we, a, pd, hold, busy, done, err};
      vecs.push_back(t);
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic acc;
      logic rdy;
      int   budget;
      acc    = 1'b0;
      budget = 0;
      while (!acc && budget < 200) begin
         @(negedge clk);
         rdy     = InReady;
         InValid = rnd_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
         InData  = b;
         @(posedge clk);
         acc = InValid && rdy;
         budget++;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL byte_timeout: byte %02h not accepted, got no InReady expected acceptance", b);
      end
   endtask

   task automatic start_load();
      @(negedge clk);
      Start   = 1'b1;
      InValid = 1'b0;
      @(posedge clk);
      #1 Start = 1'b0;
   endtask

   task automatic wait_idle();
      @(negedge clk);
      InValid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      Reset   = 1'b1;
      Start   = 1'b0;
      InValid = 1'b0;
      @(negedge clk);
      Reset = 1'b0;
   endtask

   // n words: HI = E0|i (upper bits must be dropped), LO = 5A^i
   task automatic run_load(input int n);
      logic [7:0] hb, lb, sum;
      send_byte(8'(n));
      sum = 8'(n);
      for (int i = 0; i < n; i++) begin
         hb = 8'hE0 | 8'(i);
         lb = 8'h5A ^ 8'(i);
         send_byte(hb);
         send_byte(lb);
         sum = sum + hb + lb;
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(sum);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int base_w, base_d;
      Reset   = 1'b1;
      Start   = 1'b0;
      InValid = 1'b0;
      InData  = 8'h00;

      //            st v  data   rdy we addr pdata    hold busy done err
      add_vec(1, 0, 8'h00, 1, 0, 0, 13'h0000, 1, 1, 0, 0); // COUNT
      add_vec(0, 1, 8'h01, 1, 0, 0, 13'h0000, 1, 1, 0, 0); // N=1 -> HI
      add_vec(0, 0, 8'h1F, 1, 0, 0, 13'h0000, 1, 1, 0, 0); // no valid: stay HI
      add_vec(1, 0, 8'h00, 1, 0, 0, 13'h0000, 1, 1, 0, 0); // Start in HI ignored
      add_vec(0, 1, 8'h1F, 1, 0, 0, 13'h0000, 1, 1, 0, 0); // HI byte -> LO
      add_vec(0, 1, 8'hAB, 0, 1, 0, 13'h1FAB, 1, 1, 0, 0); // LO byte -> WRITE
`ifdef LOADER_CHECKSUM_EN
      add_vec(0, 1, 8'h00, 1, 0, 0, 13'h1FAB, 1, 1, 0, 0); // byte ignored in WRITE -> CHECK
      add_vec(0, 1, 8'hCB, 0, 0, 0, 13'h1FAB, 1, 1, 1, 0); // checksum ok -> FINISH
`else
      add_vec(0, 1, 8'h00, 0, 0, 0, 13'h1FAB, 1, 1, 1, 0); // byte ignored -> FINISH
`endif
      add_vec(0, 0, 8'h00, 0, 0, 0, 13'h1FAB, 0, 0, 0, 0); // IDLE, CPU released
      add_vec(0, 1, 8'h55, 0, 0, 0, 13'h1FAB, 0, 0, 0, 0); // valid ignored in IDLE
      add_vec(1, 0, 8'h00, 1, 0, 0, 13'h1FAB, 1, 1, 0, 0); // COUNT
      add_vec(0, 1, 8'h00, 0, 0, 0, 13'h1FAB, 1, 0, 0, 1); // N=0 -> error
      add_vec(0, 0, 8'h00, 0, 0, 0, 13'h1FAB, 1, 0, 0, 1); // error sticky
      add_vec(1, 0, 8'h00, 1, 0, 0, 13'h1FAB, 1, 1, 0, 0); // Start clears error
      add_vec(0, 1, 8'h21, 0, 0, 0, 13'h1FAB, 1, 0, 0, 1); // N=33 -> error
      add_vec(1, 0, 8'h00, 1, 0, 0, 13'h1FAB, 1, 1, 0, 0); // Start clears error
      add_vec(0, 1, 8'h20, 1, 0, 0, 13'h1FAB, 1, 1, 0, 0); // N=32 accepted -> HI

      @(negedge clk);
      @(negedge clk);
      Reset = 1'b0;
      #1;
      `CHK("rst InReady", InReady, 1'b0)
      `CHK("rst PM_WE",   PM_WE,   1'b0)
      `CHK("rst PM_Addr", PM_Addr, 5'd0)
      `CHK("rst PM_Data", PM_Data, 13'h0000)
      `CHK("rst CpuHold", CpuHold, 1'b0)
      `CHK("rst Busy",    Busy,    1'b0)
      `CHK("rst Done",    Done,    1'b0)
      `CHK("rst Error",   Error,   1'b0)

      foreach (vecs[i]) begin
         @(negedge clk);
         Start   = vecs[i].start;
         InValid = vecs[i].valid;
         InData  = vecs[i].data;
         @(posedge clk);
         #1;
         `CHK($sformatf("v%0d InReady", i), InReady, vecs[i].rdy)
         `CHK($sformatf("v%0d PM_WE", i),   PM_WE,   vecs[i].we)
         `CHK($sformatf("v%0d PM_Addr", i), PM_Addr, vecs[i].addr)
         `CHK($sformatf("v%0d PM_Data", i), PM_Data, vecs[i].pdata)
         `CHK($sformatf("v%0d CpuHold", i), CpuHold, vecs[i].hold)
         `CHK($sformatf("v%0d Busy", i),    Busy,    vecs[i].busy)
         `CHK($sformatf("v%0d Done", i),    Done,    vecs[i].done)
         `CHK($sformatf("v%0d Error", i),   Error,   vecs[i].err)
      end

      // Full-depth load with randomly gapped InValid
      do_reset();
      rnd_valid = 1'b1;
      base_w = wr_addr_q.size();
      base_d = done_cnt;
      start_load();
      run_load(32);
      wait_idle();
      rnd_valid = 1'b0;
      `CHK("n32 write count", wr_addr_q.size() - base_w, 32)
      if (wr_addr_q.size() - base_w == 32) begin
         for (int k = 0; k < 32; k++) begin
            `CHK($sformatf("n32 addr%0d", k), wr_addr_q[base_w + k], 5'(k))
            `CHK($sformatf("n32 data%0d", k), wr_data_q[base_w + k], {5'(k), 8'h5A ^ 8'(k)})
         end
      end
      `CHK("n32 done count", done_cnt - base_d, 1)
      `CHK("n32 CpuHold", CpuHold, 1'b0)
      `CHK("n32 Busy", Busy, 1'b0)
      `CHK("n32 Error", Error, 1'b0)

      // Start pulsed while in HI must not disturb a two-word load
      base_w = wr_addr_q.size();
      base_d = done_cnt;
      start_load();
      send_byte(8'd2);
      @(negedge clk);
      Start   = 1'b1;
      InValid = 1'b0;
      @(posedge clk);
      #1 Start = 1'b0;
      `CHK("hi_start Busy", Busy, 1'b1)
      send_byte(8'hE0);
      send_byte(8'h5A);
      send_byte(8'hE1);
      send_byte(8'h5B);
`ifdef LOADER_CHECKSUM_EN
      send_byte(8'(8'd2 + 8'hE0 + 8'h5A + 8'hE1 + 8'h5B));
`endif
      wait_idle();
      `CHK("hi_start writes", wr_addr_q.size() - base_w, 2)
      `CHK("hi_start done", done_cnt - base_d, 1)
      `CHK("hi_start Error", Error, 1'b0)

      // Reset after HI byte of word 3 aborts without writing address 3
      base_w = wr_addr_q.size();
      start_load();
      send_byte(8'd5);
      for (int i = 0; i < 3; i++) begin
         send_byte(8'hE0 | 8'(i));
         send_byte(8'h5A ^ 8'(i));
      end
      send_byte(8'hE3);
      #2;
      Reset   = 1'b1;
      InValid = 1'b0;
      #1;
      `CHK("abort InReady", InReady, 1'b0)
      `CHK("abort PM_WE",   PM_WE,   1'b0)
      `CHK("abort PM_Addr", PM_Addr, 5'd0)
      `CHK("abort PM_Data", PM_Data, 13'h0000)
      `CHK("abort CpuHold", CpuHold, 1'b0)
      `CHK("abort Busy",    Busy,    1'b0)
      `CHK("abort Done",    Done,    1'b0)
      `CHK("abort Error",   Error,   1'b0)
      repeat (2) @(negedge clk);
      Reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      `CHK("abort writes", wr_addr_q.size() - base_w, 3)
      if (wr_addr_q.size() > 0) begin
         `CHK("abort last addr", wr_addr_q[wr_addr_q.size() - 1], 5'd2)
      end

      // Fresh single-word load after the abort
      base_w = wr_addr_q.size();
      base_d = done_cnt;
      start_load();
      send_byte(8'h01);
      send_byte(8'h1F);
      send_byte(8'hAB);
`ifdef LOADER_CHECKSUM_EN
      send_byte(8'hCB);
`endif
      wait_idle();
      `CHK("reload writes", wr_addr_q.size() - base_w, 1)
      if (wr_addr_q.size() - base_w == 1) begin
         `CHK("reload addr", wr_addr_q[base_w], 5'd0)
         `CHK("reload data", wr_data_q[base_w], 13'h1FAB)
      end
      `CHK("reload done", done_cnt - base_d, 1)
      `CHK("reload CpuHold", CpuHold, 1'b0)

`ifdef LOADER_CHECKSUM_EN
      // Bad checksum then good checksum for bytes 01,00,05 (sum 06)
      base_d = done_cnt;
      start_load();
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h05);
      send_byte(8'h07);
      wait_idle();
      `CHK("cks_bad Error", Error, 1'b1)
      `CHK("cks_bad done", done_cnt - base_d, 0)
      `CHK("cks_bad CpuHold", CpuHold, 1'b1)
      `CHK("cks_bad Busy", Busy, 1'b0)
      base_d = done_cnt;
      start_load();
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h05);
      send_byte(8'h06);
      wait_idle();
      `CHK("cks_ok Error", Error, 1'b0)
      `CHK("cks_ok done", done_cnt - base_d, 1)
      `CHK("cks_ok CpuHold", CpuHold, 1'b0)
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
